// File: rtl/rd_seq.sv
// Burst read sequencer: issues len reads starting at base, one go pulse per
// read, waits for the downstream done strobe with a per-transaction timeout.
module rd_seq #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        len,
    input  logic [ADDR_W-1:0] base,
    input  logic              ds,
    output logic              go,
    output logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic [3:0]        count,
    output logic              done,
    output logic              err
);

    // state   | meaning
    // S_IDLE  | waiting for start; outputs hold the last burst's result
    // S_ISSUE | go is high; one read launched downstream
    // S_WAIT  | waiting for ds, timer counting cycles without it
    // S_FIN   | burst complete; done pulses in the following cycle
    // S_ERR   | transaction timed out; err is set on leaving
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_FIN   = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] timer;
    logic [3:0] len_q;
    logic [3:0] count_inc;

    assign count_inc = count + 4'd1;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (len != 4'd0) ? S_ISSUE : S_FIN;
                end
            end
            S_ISSUE: state_nxt = S_WAIT;
            S_WAIT: begin
                // a strobe arriving on the timeout cycle still completes the read
                if (ds) begin
                    state_nxt = (count_inc == len_q) ? S_FIN : S_ISSUE;
                end else if (timer == TMO_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_FIN:   state_nxt = S_IDLE;
            S_ERR:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            go    <= 1'b0;
            addr  <= '0;
            count <= 4'd0;
            done  <= 1'b0;
            err   <= 1'b0;
            timer <= 8'd0;
            len_q <= 4'd0;
        end else begin
            go   <= (state_nxt == S_ISSUE);
            done <= (state == S_FIN);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err <= 1'b0;
                        if (len != 4'd0) begin
                            len_q <= len;
                            addr  <= base;
                            count <= 4'd0;
                        end
                    end
                end
                S_ISSUE: timer <= 8'd0;
                S_WAIT: begin
                    if (ds) begin
                        count <= count_inc;
                        addr  <= addr + 1'b1;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                S_ERR:   err <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rd_seq.sv
// Self-checking bench for rd_seq: directed corner cases plus randomized bursts
// checked cycle by cycle against a timing model derived from the burst rules.
module tb_rd_seq;

    localparam int AW = 8;
    localparam int TO = 15;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [3:0]    len;
    logic [AW-1:0] base;
    logic          ds;
    logic          go;
    logic [AW-1:0] addr;
    logic          busy;
    logic [3:0]    count;
    logic          done;
    logic          err;

    int            vectors;
    int            miscompares;
    int            dly[16];
    logic [3:0]    prev_count;
    logic [7:0]    prev_addr;

    rd_seq #(.ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .len   (len),
        .base  (base),
        .ds    (ds),
        .go    (go),
        .addr  (addr),
        .busy  (busy),
        .count (count),
        .done  (done),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Called at #1 after a clock edge. dly[i] is the number of cycles from the
    // i-th go pulse to its ds strobe; any value above TO means never answered.
    task automatic run_burst(input logic [7:0] b, input logic [3:0] l);
        int         go_cyc[16];
        int         ngo, nok, endc, c, idx, lastgo;
        bit         to, exp_go, want;
        logic [7:0] ea;
        nok = l;
        for (int i = 0; i < 16; i++) begin
            if (i < l && nok == l && dly[i] > TO) nok = i;
        end
        to  = (nok < l);
        ngo = to ? nok + 1 : l;
        c   = 1;
        for (int i = 0; i < 16; i++) begin
            go_cyc[i] = 0;
            if (i < ngo) begin
                go_cyc[i] = c;
                c = c + dly[i] + 1;
            end
        end
        if (l == 0)   endc = 2;
        else if (!to) endc = c + 1;
        else          endc = go_cyc[ngo-1] + TO + 2;

        start = 1'b1;
        len   = l;
        base  = b;
        idx    = 0;
        lastgo = 0;
        for (int t = 1; t <= endc + 1; t++) begin
            @(posedge clk);
            #1;
            exp_go = (idx < ngo) && (go_cyc[idx] == t);
            chk("go", go, exp_go);
            if (exp_go) begin
                ea = b + 8'(idx);
                chk("go_addr", addr, ea);
                lastgo = t;
                idx++;
            end
            chk("done", done, (!to && t == endc));
            chk("err", err, (to && t >= endc));
            chk("busy", busy, (t < endc));
            // start/len/base churn while busy must be ignored
            if (t < endc) begin
                start = 1'($urandom);
                len   = 4'($urandom);
                base  = 8'($urandom);
            end else begin
                start = 1'b0;
            end
            want = (idx > 0) && (t == lastgo + dly[idx-1]) && (dly[idx-1] <= TO);
            ds = want || ((exp_go || t >= endc - 1) && ($urandom % 2 == 1));
        end
        ds    = 1'b0;
        start = 1'b0;
        if (l != 0) begin
            prev_count = to ? 4'(nok) : l;
            prev_addr  = b + 8'(nok);
        end
        chk("final_count", count, prev_count);
        chk("final_addr", addr, prev_addr);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n = 1'b0;
        start = 1'b0;
        len   = 4'd0;
        base  = 8'd0;
        ds    = 1'b0;
        prev_count = 4'd0;
        prev_addr  = 8'd0;
        for (int i = 0; i < 16; i++) dly[i] = 2;

        #12;
        chk("rst_go", go, 0);
        chk("rst_addr", addr, 0);
        chk("rst_count", count, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // three reads, each answered two cycles after go
        for (int i = 0; i < 16; i++) dly[i] = 2;
        run_burst(8'h10, 4'd3);

        // empty burst
        run_burst(8'h55, 4'd0);

        // no response at all: timeout on the first read
        for (int i = 0; i < 16; i++) dly[i] = 99;
        run_burst(8'h20, 4'd2);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("err_hold", err, 1);
        end

        // strobe on the last legal WAIT cycle still completes
        dly[0] = TO;
        dly[1] = TO;
        run_burst(8'h30, 4'd2);

        // one cycle too late times out on the second read
        dly[0] = 1;
        dly[1] = TO + 1;
        run_burst(8'h40, 4'd3);

        // address wrap
        dly[0] = 1;
        dly[1] = 3;
        run_burst(8'hFF, 4'd2);

        // reset in the middle of a WAIT
        for (int i = 0; i < 16; i++) dly[i] = 99;
        start = 1'b1;
        len   = 4'd4;
        base  = 8'hA5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_addr", addr, 8'hA5);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_go", go, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_count", count, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_err", err, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("post_rst_done", done, 0);
            chk("post_rst_busy", busy, 0);
        end
        prev_count = 4'd0;
        prev_addr  = 8'd0;
        for (int i = 0; i < 16; i++) dly[i] = 1 + (i % 3);
        run_burst(8'h77, 4'd4);

        // randomized bursts
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 16; i++) begin
                case ($urandom % 12)
                    0:       dly[i] = TO;
                    1:       dly[i] = TO + 1;
                    2:       dly[i] = 99;
                    default: dly[i] = 1 + int'($urandom % 4);
                endcase
            end
            run_burst(8'($urandom), 4'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
